// File: rtl/vec_cmd_arbiter_pkg.sv
// vec_cmd_arbiter_pkg: opcodes, FSM states and helpers shared by the vector command arbiter
package vec_cmd_arbiter_pkg;
  localparam logic [3:0] op_add_c   = 4'b0000;
  localparam logic [3:0] op_sub_c   = 4'b0001;
  localparam logic [3:0] op_mul_c   = 4'b0010;
  localparam logic [3:0] op_sadd_c  = 4'b0100;
  localparam logic [3:0] op_smul_c  = 4'b0101;
  localparam logic [3:0] op_fma_c   = 4'b0110;
  localparam logic [3:0] op_read_c  = 4'b1000;
  localparam logic [3:0] op_write_c = 4'b1001;
  localparam logic [3:0] op_mmul_c  = 4'b1111;

  typedef enum logic [1:0] {st_idle, st_issue, st_busy, st_resp} arb_state_e;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return op inside {op_add_c, op_sub_c, op_mul_c, op_sadd_c, op_smul_c,
                      op_fma_c, op_read_c, op_write_c, op_mmul_c};
  endfunction
endpackage

// File: rtl/vec_cmd_arbiter_rr.sv
// vec_cmd_arbiter_rr: round-robin grant searching upward from the last winner, wrapping
module vec_cmd_arbiter_rr #(
  parameter int req_p  = 2,
  parameter int id_w_p = 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [req_p-1:0]  req_i,
  input  logic              en_i,
  output logic [req_p-1:0]  grant_o,
  output logic [id_w_p-1:0] id_o,
  output logic              v_o
);
  logic [id_w_p-1:0] r_ptr, w_idx, w_id;
  logic              w_hit;

  // scan from farthest to nearest so the nearest requester after r_ptr wins
  always_comb begin
    w_id  = '0;
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = req_p; k >= 1; k--) begin
      w_idx = id_w_p'((int'(r_ptr) + k) % req_p);
      if (req_i[w_idx]) begin
        w_id  = w_idx;
        w_hit = 1'b1;
      end
    end
  end

  assign v_o     = en_i & w_hit;
  assign id_o    = w_id;
  assign grant_o = v_o ? req_p'(1) << w_id : '0;

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) r_ptr <= id_w_p'(req_p - 1);
    else if (v_o) r_ptr <= w_id;
endmodule

// File: rtl/vec_cmd_arbiter.sv
// vec_cmd_arbiter: round-robin command arbiter/sequencer in front of the vector unit command port
module vec_cmd_arbiter
  import vec_cmd_arbiter_pkg::*;
#(
  parameter int req_p  = 2,
  parameter int els_p  = 8,
  parameter int vlen_p = 8,
  parameter int vdw_p  = 8,
  localparam int v_addr_width_lp = safe_clog2(els_p),
  localparam int data_width_lp   = vlen_p * vdw_p,
  localparam int req_id_width_lp = safe_clog2(req_p)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [req_p-1:0]                      req_v_i,
  output logic [req_p-1:0]                      req_ready_o,
  input  logic [req_p-1:0][3:0]                 req_op_i,
  input  logic [req_p-1:0][v_addr_width_lp-1:0] req_addrA_i,
  input  logic [req_p-1:0][v_addr_width_lp-1:0] req_addrB_i,
  input  logic [req_p-1:0][v_addr_width_lp-1:0] req_addrC_i,
  input  logic [req_p-1:0][v_addr_width_lp-1:0] req_addrD_i,
  input  logic [req_p-1:0][v_addr_width_lp-1:0] req_fma_cycles_i,
  input  logic [req_p-1:0][vdw_p-1:0]           req_scalar_i,
  input  logic [req_p-1:0][data_width_lp-1:0]   req_w_data_i,
  output logic [req_p-1:0]                      cmpl_v_o,
  output logic [req_p-1:0]                      cmpl_err_o,
  output logic [req_p-1:0]                      resp_v_o,
  output logic [data_width_lp-1:0]              resp_data_o,
  input  logic [req_p-1:0]                      resp_yumi_i,
  output logic [3:0]                            vu_op_o,
  output logic [v_addr_width_lp-1:0]            vu_addrA_o,
  output logic [v_addr_width_lp-1:0]            vu_addrB_o,
  output logic [v_addr_width_lp-1:0]            vu_addrC_o,
  output logic [v_addr_width_lp-1:0]            vu_addrD_o,
  output logic [v_addr_width_lp-1:0]            vu_fma_cycles_o,
  output logic [vdw_p-1:0]                      vu_scalar_o,
  output logic [data_width_lp-1:0]              vu_w_data_o,
  output logic                                  vu_v_o,
  input  logic                                  vu_ready_i,
  input  logic                                  vu_done_i,
  input  logic [data_width_lp-1:0]              vu_r_data_i,
  output logic                                  vu_yumi_o,
  output logic                                  busy_o
);
  typedef struct packed {
    logic [3:0]                 op;
    logic [v_addr_width_lp-1:0] addr_a;
    logic [v_addr_width_lp-1:0] addr_b;
    logic [v_addr_width_lp-1:0] addr_c;
    logic [v_addr_width_lp-1:0] addr_d;
    logic [v_addr_width_lp-1:0] fma_cycles;
    logic [vdw_p-1:0]           scalar;
    logic [data_width_lp-1:0]   w_data;
  } vec_cmd_s;

  arb_state_e                 r_state;
  vec_cmd_s                   r_cmd, w_cmd;
  logic [req_id_width_lp-1:0] r_gid, w_gid;
  logic                       r_cmpl_v, r_cmpl_err;
  logic [data_width_lp-1:0]   r_resp_data;
  logic [req_p-1:0]           w_owner;
  logic                       w_accept, w_can_accept, w_read_done, w_resp_take;

  // no accept while a completion is being reported, so the owner id stays valid
  assign w_can_accept = reset_n_i && r_state == st_idle && !r_cmpl_v;

  vec_cmd_arbiter_rr #(.req_p(req_p), .id_w_p(req_id_width_lp)) u_rr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .req_i     (req_v_i),
    .en_i      (w_can_accept),
    .grant_o   (req_ready_o),
    .id_o      (w_gid),
    .v_o       (w_accept)
  );

  assign w_cmd = {req_op_i[w_gid], req_addrA_i[w_gid], req_addrB_i[w_gid], req_addrC_i[w_gid],
                  req_addrD_i[w_gid], req_fma_cycles_i[w_gid], req_scalar_i[w_gid], req_w_data_i[w_gid]};

  assign w_owner     = req_p'(1) << r_gid;
  assign w_read_done = r_state == st_busy && vu_done_i && r_cmd.op == op_read_c;
  assign w_resp_take = r_state == st_resp && resp_yumi_i[r_gid];

  assign cmpl_v_o    = (r_cmpl_v || w_resp_take) ? w_owner : '0;
  assign cmpl_err_o  = r_cmpl_err ? w_owner : '0;
  assign resp_v_o    = r_state == st_resp ? w_owner : '0;
  assign resp_data_o = r_state == st_resp ? r_resp_data : '0;
  assign vu_v_o      = r_state == st_issue;
  assign vu_yumi_o   = w_read_done;
  assign busy_o      = r_state != st_idle;
  assign {vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrC_o, vu_addrD_o,
          vu_fma_cycles_o, vu_scalar_o, vu_w_data_o} = r_cmd;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= st_idle;
      r_cmd       <= '0;
      r_gid       <= '0;
      r_cmpl_v    <= 1'b0;
      r_cmpl_err  <= 1'b0;
      r_resp_data <= '0;
    end else begin
      r_cmpl_v   <= 1'b0;
      r_cmpl_err <= 1'b0;
      case (r_state)
        st_idle:
          if (w_accept) begin
            r_cmd <= w_cmd;
            r_gid <= w_gid;
            if (op_legal(w_cmd.op)) r_state <= st_issue;
            else begin
              r_cmpl_v   <= 1'b1;
              r_cmpl_err <= 1'b1;
            end
          end
        st_issue: if (vu_ready_i) r_state <= st_busy;
        st_busy:
          if (w_read_done) begin
            r_resp_data <= vu_r_data_i;
            r_state     <= st_resp;
          end else if (vu_done_i) begin
            r_cmpl_v <= 1'b1;
            r_state  <= st_idle;
          end
        st_resp:
          if (w_resp_take) begin
            r_resp_data <= '0;
            r_state     <= st_idle;
          end
        default: r_state <= st_idle;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_cmd_arbiter.sv
// tb_vec_cmd_arbiter: directed and randomized checks of vec_cmd_arbiter against a queue-based reference
module tb_vec_cmd_arbiter;
  localparam int rq = 2, aw = 3, dw = 64, sw = 8;

  typedef struct packed {
    logic [3:0]    op;
    logic [aw-1:0] a, b, c, d, f;
    logic [sw-1:0] s;
    logic [dw-1:0] w;
  } cmd_t;

  logic                   clk = 1'b0;
  logic                   reset_n_i = 1'b0;
  logic [rq-1:0]          req_v_i = '0, req_ready_o;
  logic [rq-1:0][3:0]     req_op_i = '0;
  logic [rq-1:0][aw-1:0]  req_addrA_i = '0, req_addrB_i = '0, req_addrC_i = '0, req_addrD_i = '0;
  logic [rq-1:0][aw-1:0]  req_fma_cycles_i = '0;
  logic [rq-1:0][sw-1:0]  req_scalar_i = '0;
  logic [rq-1:0][dw-1:0]  req_w_data_i = '0;
  logic [rq-1:0]          cmpl_v_o, cmpl_err_o, resp_v_o;
  logic [rq-1:0]          resp_yumi_i = '0;
  logic [dw-1:0]          resp_data_o;
  logic [3:0]             vu_op_o;
  logic [aw-1:0]          vu_addrA_o, vu_addrB_o, vu_addrC_o, vu_addrD_o, vu_fma_cycles_o;
  logic [sw-1:0]          vu_scalar_o;
  logic [dw-1:0]          vu_w_data_o;
  logic                   vu_v_o, vu_yumi_o, busy_o;
  logic                   vu_ready_i = 1'b0, vu_done_i = 1'b0;
  logic [dw-1:0]          vu_r_data_i = '0;

  always #5 clk = ~clk;

  vec_cmd_arbiter dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addrA_i(req_addrA_i), .req_addrB_i(req_addrB_i), .req_addrC_i(req_addrC_i),
    .req_addrD_i(req_addrD_i), .req_fma_cycles_i(req_fma_cycles_i),
    .req_scalar_i(req_scalar_i), .req_w_data_i(req_w_data_i),
    .cmpl_v_o(cmpl_v_o), .cmpl_err_o(cmpl_err_o), .resp_v_o(resp_v_o),
    .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
    .vu_op_o(vu_op_o), .vu_addrA_o(vu_addrA_o), .vu_addrB_o(vu_addrB_o),
    .vu_addrC_o(vu_addrC_o), .vu_addrD_o(vu_addrD_o), .vu_fma_cycles_o(vu_fma_cycles_o),
    .vu_scalar_o(vu_scalar_o), .vu_w_data_o(vu_w_data_o), .vu_v_o(vu_v_o),
    .vu_ready_i(vu_ready_i), .vu_done_i(vu_done_i), .vu_r_data_i(vu_r_data_i),
    .vu_yumi_o(vu_yumi_o), .busy_o(busy_o)
  );

  int total = 0, bad = 0;
  cmd_t q [rq][$];
  cmd_t cur;
  int mphase = 0, owner = 0, last_g = rq - 1;
  bit cmpl_pend = 0, err_pend = 0, rd_forced = 0;
  int ready_wait = 0, done_wait = 0, yumi_wait = 0;
  int k_ready = -1, k_done = -1, k_yumi = -1;
  logic [dw-1:0] exp_data = '0, rd_force = '0;
  int pops = 0, abandoned = 0, seen_cmpl = 0, pushed = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hF};
  endfunction

  function automatic int pick();
    for (int k = 1; k <= rq; k++)
      if (q[(last_g + k) % rq].size() > 0) return (last_g + k) % rq;
    return -1;
  endfunction

  function automatic bit idle();
    return mphase == 0 && !cmpl_pend && q[0].size() == 0 && q[1].size() == 0;
  endfunction

  function automatic cmd_t mk(input logic [3:0] op, input logic [aw-1:0] a, b, d);
    cmd_t c;
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    c = r[90:0];
    c.op = op;
    c.a = a;
    c.b = b;
    c.d = d;
    return c;
  endfunction

  // one clock: drive at negedge, check outputs against the model, then advance the model
  task automatic cycle();
    int g;
    cmd_t h;
    logic [95:0] r;
    logic [rq-1:0] own, exp_rdy, exp_cv;
    bit old_cmpl;
    @(negedge clk);
    for (int i = 0; i < rq; i++) begin
      r = {$urandom, $urandom, $urandom};
      h = (q[i].size() > 0) ? q[i][0] : cmd_t'(r[90:0]);
      req_v_i[i] = q[i].size() > 0;
      req_op_i[i] = h.op;
      req_addrA_i[i] = h.a;
      req_addrB_i[i] = h.b;
      req_addrC_i[i] = h.c;
      req_addrD_i[i] = h.d;
      req_fma_cycles_i[i] = h.f;
      req_scalar_i[i] = h.s;
      req_w_data_i[i] = h.w;
    end
    vu_ready_i = (mphase == 1) ? (ready_wait == 0) : 1'($urandom);
    vu_done_i = (mphase == 2) && (done_wait == 0);
    vu_r_data_i = rd_forced ? rd_force : {$urandom, $urandom};
    resp_yumi_i = 2'($urandom);
    if (mphase == 3) resp_yumi_i[owner] = (yumi_wait == 0);
    #1;
    own = rq'(1) << owner;
    g = pick();
    exp_rdy = (mphase == 0 && !cmpl_pend && g >= 0) ? rq'(1) << g : '0;
    exp_cv = (cmpl_pend || (mphase == 3 && resp_yumi_i[owner])) ? own : '0;
    chk("ready", req_ready_o, exp_rdy);
    chk("vu_v", vu_v_o, mphase == 1);
    chk("cmpl_v", cmpl_v_o, exp_cv);
    chk("cmpl_err", cmpl_err_o, err_pend ? own : '0);
    chk("resp_v", resp_v_o, mphase == 3 ? own : '0);
    chk("resp_data", resp_data_o, mphase == 3 ? exp_data : '0);
    chk("vu_yumi", vu_yumi_o, mphase == 2 && vu_done_i && cur.op == 4'h8);
    chk("busy", busy_o, mphase != 0);
    if (mphase != 0)
      chk("vu_fields", {vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrC_o, vu_addrD_o,
                        vu_fma_cycles_o, vu_scalar_o, vu_w_data_o}, cur);
    seen_cmpl += $countones(cmpl_v_o);
    old_cmpl = cmpl_pend;
    cmpl_pend = 0;
    err_pend = 0;
    case (mphase)
      0: if (!old_cmpl && g >= 0) begin
           cur = q[g].pop_front();
           pops++;
           owner = g;
           last_g = g;
           if (legal(cur.op)) begin
             mphase = 1;
             ready_wait = k_ready >= 0 ? k_ready : int'($urandom_range(0, 2));
           end else begin
             cmpl_pend = 1;
             err_pend = 1;
           end
         end
      1: if (vu_ready_i) begin
           mphase = 2;
           done_wait = k_done >= 0 ? k_done : int'($urandom_range(0, 3));
         end else ready_wait--;
      2: if (vu_done_i) begin
           if (cur.op == 4'h8) begin
             mphase = 3;
             exp_data = vu_r_data_i;
             yumi_wait = k_yumi >= 0 ? k_yumi : int'($urandom_range(0, 3));
           end else begin
             mphase = 0;
             cmpl_pend = 1;
           end
         end else done_wait--;
      3: if (resp_yumi_i[owner]) mphase = 0; else yumi_wait--;
      default: ;
    endcase
  endtask

  task automatic run(input string tag, input int max);
    int n = 0;
    while (!idle() && n < max) begin
      cycle();
      n++;
    end
    chk(tag, idle(), 1);
  endtask

  initial begin
    req_v_i = 2'b11;
    vu_done_i = 1'b1;
    vu_ready_i = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_ctl", {req_ready_o, cmpl_v_o, cmpl_err_o, resp_v_o, vu_v_o, vu_yumi_o, busy_o}, 0);
    chk("rst_data", resp_data_o, 0);
    chk("rst_fields", {vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrC_o, vu_addrD_o,
                       vu_fma_cycles_o, vu_scalar_o, vu_w_data_o}, 0);
    @(negedge clk);
    req_v_i = '0;
    vu_done_i = 1'b0;
    reset_n_i = 1'b1;

    k_ready = 0;
    k_done = 2;
    q[0].push_back(mk(4'h0, 3'd1, 3'd2, 3'd3));
    cycle();
    cycle();
    chk("add_addrs", {vu_addrA_o, vu_addrB_o, vu_addrD_o}, {3'd1, 3'd2, 3'd3});
    run("add_end", 20);

    k_done = 1;
    k_yumi = 3;
    rd_forced = 1;
    rd_force = 64'hDEADBEEF_01234567;
    q[1].push_back(mk(4'h8, 3'd5, 3'd0, 3'd0));
    run("read_end", 30);
    rd_forced = 0;

    k_ready = -1;
    k_done = -1;
    k_yumi = -1;
    for (int i = 0; i < 4; i++) begin
      q[0].push_back(mk(4'h9, 3'($urandom), 3'($urandom), 3'($urandom)));
      q[1].push_back(mk(4'h9, 3'($urandom), 3'($urandom), 3'($urandom)));
    end
    run("rr_end", 200);

    q[0].push_back(mk(4'h3, 3'd1, 3'd1, 3'd1));
    run("illegal_end", 10);

    k_ready = 5;
    k_done = 0;
    q[1].push_back(mk(4'h1, 3'd4, 3'd6, 3'd7));
    run("hold_end", 30);

    k_ready = 0;
    k_done = 30;
    q[0].push_back(mk(4'h9, 3'd2, 3'd2, 3'd2));
    for (int n = 0; n < 10 && mphase != 2; n++) cycle();
    chk("reach_busy", mphase, 2);
    cycle();
    cycle();
    @(negedge clk);
    req_v_i = 2'b11;
    reset_n_i = 1'b0;
    #1;
    chk("midrst_ctl", {req_ready_o, cmpl_v_o, cmpl_err_o, resp_v_o, vu_v_o, vu_yumi_o, busy_o}, 0);
    chk("midrst_data", resp_data_o, 0);
    chk("midrst_fields", {vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrC_o, vu_addrD_o,
                          vu_fma_cycles_o, vu_scalar_o, vu_w_data_o}, 0);
    @(negedge clk);
    req_v_i = '0;
    reset_n_i = 1'b1;
    mphase = 0;
    cmpl_pend = 0;
    err_pend = 0;
    last_g = rq - 1;
    abandoned++;
    k_ready = -1;
    k_done = -1;
    q[0].push_back(mk(4'h0, 3'd1, 3'd2, 3'd3));
    q[1].push_back(mk(4'h2, 3'd3, 3'd2, 3'd1));
    cycle();
    chk("post_rst_grant", req_ready_o, 2'b01);
    run("post_rst_end", 60);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0 && pushed < 80) begin
        logic [3:0] op;
        op = ($urandom_range(0, 3) == 0) ? 4'h8 : 4'($urandom);
        q[$urandom_range(0, rq - 1)].push_back(mk(op, 3'($urandom), 3'($urandom), 3'($urandom)));
        pushed++;
      end
      cycle();
    end
    run("rand_end", 800);

    chk("cmpl_count", seen_cmpl, pops - abandoned);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
